inst_fetcher: RTL and testbench

INST_FETCHER -- requirements
Module: inst_fetcher

---
 rtl/inst_fetcher_pkg.sv | 33 +++
 rtl/inst_fetcher_if.sv | 32 +++
 rtl/inst_fetcher_icache.sv | 47 ++++
 rtl/inst_fetcher.sv | 102 ++++++++++
 tb/tb_inst_fetcher.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetcher and its cache.
// Pure declarations, no timing.
// No flow control of its own.
package inst_fetcher_pkg;

    // Default cache geometry: direct-mapped, one 32-bit instruction per line.
    localparam int ICACHE_LINES_DEF = 256;
    localparam int IDX_W_DEF        = $clog2(ICACHE_LINES_DEF);
    localparam int TAG_W_DEF        = 30 - IDX_W_DEF;

    // PC loaded on reset.
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Memory-controller access direction flags; the fetcher only ever reads.
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Fetch FSM encoding.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    // One emitted instruction with its address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } issue_t;

    // Sequential PC advance; wraps 0xFFFFFFFC -> 0 naturally in 32 bits.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher-side bundle: memory request/response, issue output, ROB redirect.
// Wires only, no latency.
// issue_stall is the downstream backpressure; drop_flag aborts memory.
interface inst_fetcher_if;
    logic        en_signal_to_mem;
    logic [31:0] pc_to_mem;
    logic        drop_flag_to_mem;
    logic        ok_flag_from_mem;
    logic [31:0] inst_from_mem;
    logic        issue_stall;
    logic        inst_valid_to_issue;
    logic [31:0] inst_to_issue;
    logic [31:0] pc_to_issue;
    logic        rollback_flag_from_rob;
    logic [31:0] target_pc_from_rob;

    // Fetcher side.
    modport master (
        output en_signal_to_mem, pc_to_mem, drop_flag_to_mem,
        output inst_valid_to_issue, inst_to_issue, pc_to_issue,
        input  ok_flag_from_mem, inst_from_mem, issue_stall,
        input  rollback_flag_from_rob, target_pc_from_rob
    );

    // Memory / issue queue / ROB side.
    modport slave (
        input  en_signal_to_mem, pc_to_mem, drop_flag_to_mem,
        input  inst_valid_to_issue, inst_to_issue, pc_to_issue,
        output ok_flag_from_mem, inst_from_mem, issue_stall,
        output rollback_flag_from_rob, target_pc_from_rob
    );
endinterface

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache, one instruction per line.
// Lookup is combinational (0 cycles); a write is visible on the next cycle.
// No backpressure: the write port is always accepted.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEF,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_hit,
    output logic [31:0]      o_rd_dat,
    input  logic             i_wr_vld,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_dat
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Valid bits: cleared together on reset, set by a line fill.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (i_wr_vld) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data storage: no reset needed, guarded by the valid bits.
    always_ff @(posedge clk_in) begin
        if (i_wr_vld) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_dat;
        end
    end

    assign o_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_dat = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: cache lookup, single-outstanding miss fill, issue pulse.
// Hit emits on the next edge; a miss costs memory latency + 2 cycles.
// issue_stall holds the PC with no emission; rdy_in low freezes everything.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int ICACHE_LINES = ICACHE_LINES_DEF
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    inst_fetcher_if.master io_fetch
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_en;
    logic [31:0] r_pc_to_mem;
    logic        r_inst_vld;
    issue_t      r_issue;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [31:0]      w_hit_dat;
    logic             w_fill;

    assign w_idx = r_pc[IDX_W+1:2];
    assign w_tag = r_pc[31:IDX_W+2];

    // A response only fills the cache while a request is really outstanding
    // and nothing with higher priority (reset, freeze, rollback) is active.
    assign w_fill = !rst_in && rdy_in && !io_fetch.rollback_flag_from_rob &&
                    (r_state == ST_WAIT_MEM) && io_fetch.ok_flag_from_mem;

    inst_fetcher_icache #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_rd_idx (w_idx),
        .i_rd_tag (w_tag),
        .o_hit    (w_hit),
        .o_rd_dat (w_hit_dat),
        .i_wr_vld (w_fill),
        .i_wr_idx (w_idx),
        .i_wr_tag (w_tag),
        .i_wr_dat (io_fetch.inst_from_mem)
    );

    // Fetch FSM: reset > freeze > rollback > lookup/miss or fill completion.
    // While frozen the pulse outputs drop so no request or instruction is
    // seen twice; address/data outputs keep their last values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_en        <= 1'b0;
            r_pc_to_mem <= 32'h0;
            r_inst_vld  <= 1'b0;
            r_issue     <= '0;
        end else if (!rdy_in) begin
            r_en       <= 1'b0;
            r_inst_vld <= 1'b0;
        end else begin
            r_en       <= 1'b0;
            r_inst_vld <= 1'b0;
            if (io_fetch.rollback_flag_from_rob) begin
                r_pc    <= io_fetch.target_pc_from_rob;
                r_state <= ST_IDLE;
            end else if (r_state == ST_IDLE) begin
                if (!io_fetch.issue_stall) begin
                    if (w_hit) begin
                        r_inst_vld <= 1'b1;
                        r_issue    <= '{pc: r_pc, inst: w_hit_dat};
                        r_pc       <= next_pc(r_pc);
                    end else begin
                        r_en        <= 1'b1;
                        r_pc_to_mem <= r_pc;
                        r_state     <= ST_WAIT_MEM;
                    end
                end
            end else if (io_fetch.ok_flag_from_mem) begin
                // Line written this edge; the next IDLE cycle hits on it.
                r_state <= ST_IDLE;
            end
        end
    end

    assign io_fetch.en_signal_to_mem    = r_en;
    assign io_fetch.pc_to_mem           = r_pc_to_mem;
    assign io_fetch.drop_flag_to_mem    = io_fetch.rollback_flag_from_rob;
    assign io_fetch.inst_valid_to_issue = r_inst_vld;
    assign io_fetch.inst_to_issue       = r_issue.inst;
    assign io_fetch.pc_to_issue         = r_issue.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus random traffic,
// each cycle compared with a queue/array-level model of fetch behaviour.
module tb_inst_fetcher;

    localparam int LINES = 256;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    inst_fetcher_if bus ();

    inst_fetcher #(.ICACHE_LINES(LINES)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Next-cycle stimulus.
    logic        in_rst, in_rdy, in_stall, in_rb, in_ok;
    logic [31:0] in_tgt, in_inst;
    logic        samp_drop;

    // Memory responder state.
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_dat = 0;
    int          lat = 5;

    // Behavioural model: PC, waiting flag, cache as line -> (address, word).
    logic [31:0] m_pc = 0;
    bit          m_wait = 0;
    logic [31:0] c_addr [int];
    logic [31:0] c_data [int];
    logic        e_en = 0, e_vld = 0;
    logic [31:0] e_pcm = 0, e_inst = 0, e_pci = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int line;
        line = int'((m_pc >> 2) % LINES);
        if (in_rst) begin
            m_pc = 0; m_wait = 0;
            c_addr.delete(); c_data.delete();
            e_en = 0; e_vld = 0; e_pcm = 0; e_inst = 0; e_pci = 0;
        end else if (!in_rdy) begin
            e_en = 0; e_vld = 0;
        end else begin
            e_en = 0; e_vld = 0;
            if (in_rb) begin
                m_pc = in_tgt; m_wait = 0;
            end else if (m_wait) begin
                if (in_ok) begin
                    c_addr[line] = m_pc; c_data[line] = in_inst; m_wait = 0;
                end
            end else if (!in_stall) begin
                if (c_addr.exists(line) && c_addr[line] == m_pc) begin
                    e_vld = 1; e_inst = c_data[line]; e_pci = m_pc; m_pc = m_pc + 32'd4;
                end else begin
                    e_en = 1; e_pcm = m_pc; m_wait = 1;
                end
            end
        end
    endtask

    // Decide this cycle's memory response (only delivered while rdy is high).
    task automatic prepare_mem(input bit allow_spurious);
        in_ok = 0; in_inst = $urandom;
        if (pend && in_rdy && !in_rst) begin
            if (pend_cnt > 1) pend_cnt--;
            else begin in_ok = 1; in_inst = pend_dat; pend = 0; end
        end else if (!pend && allow_spurious && $urandom_range(15) == 0) begin
            in_ok = 1;
        end
    endtask

    // One cycle: drive, check combinational drop, advance model, compare outputs.
    task automatic step();
        rst = in_rst; rdy = in_rdy;
        bus.issue_stall = in_stall;
        bus.rollback_flag_from_rob = in_rb;
        bus.target_pc_from_rob = in_tgt;
        bus.ok_flag_from_mem = in_ok;
        bus.inst_from_mem = in_inst;
        #1;
        samp_drop = bus.drop_flag_to_mem;
        chk1("drop_flag", samp_drop, in_rb);
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk1("en_signal", bus.en_signal_to_mem, e_en);
        chk("pc_to_mem", bus.pc_to_mem, e_pcm);
        chk1("inst_valid", bus.inst_valid_to_issue, e_vld);
        chk("inst_to_issue", bus.inst_to_issue, e_inst);
        chk("pc_to_issue", bus.pc_to_issue, e_pci);
        if (in_rst || in_rb) pend = 0;
        if (bus.en_signal_to_mem === 1'b1) begin
            pend = 1; pend_cnt = lat; pend_dat = mem_word(bus.pc_to_mem);
        end
    endtask

    task automatic rollback_to(input logic [31:0] t);
        in_rb = 1; in_tgt = t;
        prepare_mem(0);
        step();
        chk1("rb_drop", samp_drop, 1'b1);
        chk1("rb_no_vld", bus.inst_valid_to_issue, 1'b0);
        chk1("rb_no_en", bus.en_signal_to_mem, 1'b0);
        in_rb = 0;
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] addr);
        prepare_mem(0);
        step();
        chk1({name, "_en"}, bus.en_signal_to_mem, 1'b1);
        chk({name, "_pcm"}, bus.pc_to_mem, addr);
    endtask

    task automatic run_until_valid(input string name, input logic [31:0] inst, input logic [31:0] pc);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            prepare_mem(0);
            step();
            if (bus.inst_valid_to_issue === 1'b1) seen = 1;
        end
        chk1({name, "_seen"}, seen, 1'b1);
        chk({name, "_inst"}, bus.inst_to_issue, inst);
        chk({name, "_pc"}, bus.pc_to_issue, pc);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return 32'($urandom_range(15)) << 2;
            1:       return 32'h400 + (32'($urandom_range(7)) << 2);
            2:       return 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
            default: return 32'h100 + (32'($urandom_range(7)) << 2);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        in_rst = 1; in_rdy = 1; in_stall = 0; in_rb = 0; in_ok = 0;
        in_tgt = 0; in_inst = 0;
        rst = 1; rdy = 1;
        bus.issue_stall = 0; bus.rollback_flag_from_rob = 0;
        bus.target_pc_from_rob = 0; bus.ok_flag_from_mem = 0; bus.inst_from_mem = 0;

        // Reset state.
        step();
        chk1("rst_en", bus.en_signal_to_mem, 1'b0);
        chk1("rst_vld", bus.inst_valid_to_issue, 1'b0);
        chk("rst_inst", bus.inst_to_issue, 32'h0);
        chk("rst_pci", bus.pc_to_issue, 32'h0);
        chk("rst_pcm", bus.pc_to_mem, 32'h0);
        in_rst = 0;

        // Cold miss at PC 0, 5-cycle memory, then emission and next request.
        lat = 5;
        expect_fetch("cold0", 32'h0);
        for (int c = 1; c <= 5; c++) begin
            prepare_mem(0);
            step();
            chk1("cold_wait_vld", bus.inst_valid_to_issue, 1'b0);
            chk1("cold_wait_en", bus.en_signal_to_mem, 1'b0);
        end
        prepare_mem(0);
        step();
        chk1("cold_vld", bus.inst_valid_to_issue, 1'b1);
        chk("cold_inst", bus.inst_to_issue, 32'h0000_0013);
        chk("cold_pc", bus.pc_to_issue, 32'h0);
        chk1("cold_vld_no_en", bus.en_signal_to_mem, 1'b0);
        expect_fetch("next4", 32'h4);

        // Refetch after rollback to 0 hits one cycle later.
        rollback_to(32'h0);
        prepare_mem(0);
        step();
        chk1("refetch_vld", bus.inst_valid_to_issue, 1'b1);
        chk("refetch_inst", bus.inst_to_issue, 32'h0000_0013);
        chk1("refetch_no_en", bus.en_signal_to_mem, 1'b0);

        // Stall on a hit for 10 cycles, then release.
        rollback_to(32'h0);
        in_stall = 1;
        for (int c = 0; c < 10; c++) begin
            prepare_mem(0);
            step();
            chk1("stall_vld", bus.inst_valid_to_issue, 1'b0);
            chk1("stall_en", bus.en_signal_to_mem, 1'b0);
        end
        in_stall = 0;
        prepare_mem(0);
        step();
        chk1("release_vld", bus.inst_valid_to_issue, 1'b1);
        chk("release_pc", bus.pc_to_issue, 32'h0);

        // Rollback in the response cycle: dropped, no fill.
        expect_fetch("miss4", 32'h4);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            prepare_mem(0);
            if (in_ok) begin
                in_rb = 1; in_tgt = 32'h100; found = 1;
            end
            step();
        end
        chk1("rbok_found", found, 1'b1);
        chk1("rbok_drop", samp_drop, 1'b1);
        chk1("rbok_no_vld", bus.inst_valid_to_issue, 1'b0);
        in_rb = 0;
        expect_fetch("after_rb100", 32'h100);
        rollback_to(32'h4);
        expect_fetch("still_miss4", 32'h4);

        // Freeze mid-wait, then completion.
        prepare_mem(0);
        step();
        in_rdy = 0;
        for (int c = 0; c < 3; c++) begin
            prepare_mem(0);
            step();
            chk1("frz_en", bus.en_signal_to_mem, 1'b0);
            chk1("frz_vld", bus.inst_valid_to_issue, 1'b0);
        end
        in_rdy = 1;
        run_until_valid("frz_done", mem_word(32'h4), 32'h4);

        // Same index, different tags: each access misses and replaces.
        rollback_to(32'h400);
        expect_fetch("alias400", 32'h400);
        run_until_valid("alias400", mem_word(32'h400), 32'h400);
        rollback_to(32'h0);
        expect_fetch("alias000", 32'h0);
        run_until_valid("alias000", 32'h0000_0013, 32'h0);
        rollback_to(32'h400);
        expect_fetch("alias400b", 32'h400);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_rst   = ($urandom_range(199) == 0);
            in_rdy   = ($urandom_range(9) != 0);
            in_stall = ($urandom_range(3) == 0);
            in_rb    = ($urandom_range(24) == 0);
            in_tgt   = pick_target();
            lat      = $urandom_range(6, 1);
            prepare_mem(1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
